// File: rtl/block_ram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between NUM_REQ requesters,
// with optional bounded lock bursts and in-order read data return.
module block_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            ram_en,
  output logic                            ram_we,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  output logic [DATA_WIDTH-1:0]           ram_wdata,
  input  logic [DATA_WIDTH-1:0]           ram_rdata
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam int unsigned TAG_D = RD_LATENCY + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W-1:0]   cand;
  logic [NUM_REQ-1:0] grant;
  logic              accept;
  logic [ID_W-1:0]   sel_id;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  logic [TAG_D-1:0]  tag_v;
  logic [ID_W-1:0]   tag_id [TAG_D];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
  endfunction

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      owner    <= owner_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          if (req_lock[pick_id] && (MAX_BURST > 1)) begin
            state_nxt    = S_LOCKED;
            owner_nxt    = pick_id;
            beat_cnt_nxt = CNT_W'(1);
          end else begin
            rr_ptr_nxt = ptr_inc(pick_id);
          end
        end
      end
      S_LOCKED: begin
        if (!req_valid[owner]) begin
          state_nxt    = S_IDLE;
          rr_ptr_nxt   = ptr_inc(owner);
          beat_cnt_nxt = '0;
        end else if (!req_lock[owner] || (beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
          state_nxt    = S_IDLE;
          rr_ptr_nxt   = ptr_inc(owner);
          beat_cnt_nxt = '0;
        end else begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant: locked owner only, otherwise the round-robin pick
  always_comb begin
    grant = '0;
    if (state == S_LOCKED) grant[owner] = req_valid[owner];
    else if (pick_found)   grant[pick_id] = 1'b1;
  end

  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign accept    = |grant;
  assign sel_id    = (state == S_LOCKED) ? owner : pick_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= accept;
      ram_we <= accept & req_we[sel_id];
      if (accept) begin
        ram_addr  <= addr_arr[sel_id];
        ram_wdata <= wdata_arr[sel_id];
      end
    end
  end

  // Read tags ride alongside the RAM latency so data returns to its issuer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned k = 0; k < TAG_D; k++) tag_id[k] <= '0;
    end else begin
      tag_v     <= {tag_v[TAG_D-2:0], accept & ~req_we[sel_id]};
      tag_id[0] <= sel_id;
      for (int unsigned k = 1; k < TAG_D; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= tag_v[RD_LATENCY] ? (NUM_REQ'(1) << tag_id[RD_LATENCY]) : '0;
      if (tag_v[RD_LATENCY]) rsp_rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_block_ram_arbiter.sv
// Scoreboard bench for block_ram_arbiter: queued requesters, RAM model, and a
// rule-level arbitration/memory reference model checked every cycle.
module tb_block_ram_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned RL = 1;
  localparam int unsigned MB = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct { bit we; bit lock; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
  typedef struct { int id; logic [DW-1:0] data; int due; } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, ram_wdata, ram_rdata;
  logic            ram_en, ram_we;
  logic [AW-1:0]   ram_addr;

  cmd_t          pend [N][$];
  cmd_t          cur  [N];
  rsp_t          exp_rsp [$];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] rd_pipe [RL];
  logic [N-1:0]  acc = '0;
  bit            rand_mode = 1'b0;
  int            cyc = 0, checks = 0, errors = 0;
  int            m_ptr = 0, m_owner = -1, m_beats = 0;
  logic          e_en = 1'b0, e_we = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  block_ram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                      .RD_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(int a);
    return DW'(a * 257) ^ DW'(16'h5A5A);
  endfunction

  // Single-port RAM with RL cycles of read latency
  assign ram_rdata = rd_pipe[RL-1];
  initial begin
    for (int a = 0; a < int'(DEPTH); a++) mem[a] = init_word(a);
    for (int k = 0; k < int'(RL); k++) rd_pipe[k] = '0;
    forever begin
      @(posedge clk);
      if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) rd_pipe[0] <= mem[ram_addr];
      for (int k = 1; k < int'(RL); k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we    = 1'($urandom_range(0, 1));
    c.lock  = ($urandom_range(0, 2) == 0);
    c.addr  = AW'($urandom_range(0, 7));
    c.wdata = DW'($urandom);
    return c;
  endfunction

  task automatic push(int i, bit we, bit lock, int addr, int data);
    cmd_t c;
    c.we = we; c.lock = lock; c.addr = AW'(addr); c.wdata = DW'(data);
    pend[i].push_back(c);
  endtask

  // Requesters: present queue head until accepted
  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      if (acc[i] && pend[i].size() > 0) void'(pend[i].pop_front());
      if (rand_mode && pend[i].size() == 0 && $urandom_range(0, 3) != 0) pend[i].push_back(rand_cmd());
      if (pend[i].size() > 0) begin
        cur[i] = pend[i][0];
        req_valid[i] = 1'b1;
      end else begin
        req_valid[i] = 1'b0;
      end
      req_we[i]   = cur[i].we;
      req_lock[i] = cur[i].lock;
      req_addr[i*AW +: AW]  = cur[i].addr;
      req_wdata[i*DW +: DW] = cur[i].wdata;
    end
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      cur[i].we = 1'b0; cur[i].lock = 1'b0; cur[i].addr = '0; cur[i].wdata = '0;
    end
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      drive();
    end
  end

  // Reference model and monitor, evaluated mid-cycle
  task automatic monitor_step();
    logic [N-1:0] er;
    logic [N-1:0] oh;
    rsp_t r;
    int g;
    if (!rst_n) begin
      chk("reset_outputs", 64'({req_ready, ram_en, ram_we, ram_addr, ram_wdata, rsp_valid, rsp_rdata}), 64'(0));
      m_ptr = 0; m_owner = -1; m_beats = 0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      exp_rsp.delete();
      acc = '0;
      return;
    end
    g  = -1;
    er = '0;
    if (m_owner >= 0) begin
      if (req_valid[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < int'(N); k++)
        if (g < 0 && req_valid[(m_ptr + k) % int'(N)]) g = (m_ptr + k) % int'(N);
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("ram_cmd", 64'({ram_en, ram_we, ram_addr, ram_wdata}), 64'({e_en, e_we, e_addr, e_wdata}));
    if (exp_rsp.size() > 0 && exp_rsp[0].due <= cyc) begin
      r  = exp_rsp.pop_front();
      oh = '0;
      oh[r.id] = 1'b1;
      chk("rsp_valid", 64'(rsp_valid), 64'(oh));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'(0));
    end
    acc = req_valid & req_ready;

    e_en = (g >= 0);
    e_we = 1'b0;
    if (g >= 0) begin
      e_we    = cur[g].we;
      e_addr  = cur[g].addr;
      e_wdata = cur[g].wdata;
      if (cur[g].we) shadow[cur[g].addr] = cur[g].wdata;
      else begin
        r.id = g; r.data = shadow[cur[g].addr]; r.due = cyc + 2 + int'(RL);
        exp_rsp.push_back(r);
      end
    end
    if (m_owner >= 0) begin
      if (g < 0) begin
        m_ptr = (m_owner + 1) % int'(N); m_owner = -1;
      end else begin
        m_beats++;
        if (!cur[g].lock || m_beats == int'(MB)) begin
          m_ptr = (m_owner + 1) % int'(N); m_owner = -1;
        end
      end
    end else if (g >= 0) begin
      if (cur[g].lock && MB > 1) begin
        m_owner = g; m_beats = 1;
      end else begin
        m_ptr = (g + 1) % int'(N);
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  function automatic bit busy();
    for (int i = 0; i < int'(N); i++) if (pend[i].size() > 0) return 1'b1;
    return exp_rsp.size() > 0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy() && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 400), 64'(1));
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n;
    for (int a = 0; a < int'(DEPTH); a++) shadow[a] = init_word(a);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);

    // Write then read back the same address
    push(0, 1, 0, 'h10, 'hBEEF);
    push(0, 0, 0, 'h10, 0);
    wait_idle();

    // Both requesters continuously valid, no lock
    for (int k = 0; k < 4; k++) begin
      push(0, 1, 0, 'h20 + k, 'h1000 + k);
      push(1, 1, 0, 'h30 + k, 'h2000 + k);
    end
    wait_idle();

    // Long lock stream capped at MB beats while the other waits
    for (int k = 0; k < 6; k++) push(1, 1, 1, 'h40 + k, 'h4000 + k);
    for (int k = 0; k < 2; k++) push(0, 0, 0, 'h40 + k, 0);
    wait_idle();

    // Lock ended by a lock=0 beat, then by the owner dropping valid
    push(0, 1, 1, 'h50, 'h5000);
    push(0, 1, 0, 'h51, 'h5001);
    push(0, 0, 0, 'h50, 0);
    push(1, 0, 0, 'h51, 0);
    wait_idle();
    push(0, 1, 1, 'h60, 'h6000);
    push(1, 1, 0, 'h61, 'h6001);
    wait_idle();

    // Back-to-back reads from both requesters, returned in order
    push(0, 1, 0, 'h01, 'h1111);
    push(1, 1, 0, 'h02, 'h2222);
    wait_idle();
    push(0, 0, 0, 'h01, 0);
    push(1, 0, 0, 'h02, 0);
    wait_idle();

    rand_mode = 1'b1;
    repeat (3000) @(posedge clk);
    rand_mode = 1'b0;
    wait_idle();

    // Reset while a read is in flight
    push(0, 0, 0, 'h10, 0);
    n = 0;
    while (!acc[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("read_accepted", 64'(acc[0]), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_now", 64'({req_ready, ram_en, ram_we, ram_addr, ram_wdata, rsp_valid, rsp_rdata}), 64'(0));
    push(0, 1, 0, 'h70, 'h7000);
    push(1, 1, 0, 'h71, 'h7001);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
